// File: rtl/banked_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : banked_mem_pkg
// Brief    : Shared types, field-offset helpers and ROM generator function
//            for the banked ROM/RAM memory.
// Revision : 1.0 - initial release
// ============================================================================
package banked_mem_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_WORD_W     = 3;
    localparam int DEF_BANK_SEL_W = 3;

    // Address layout is {region, bank, word}, LSB first.
    localparam int WORD_LSB   = 0;
    localparam int BANK_LSB   = WORD_LSB + DEF_WORD_W;
    localparam int REGION_BIT = BANK_LSB + DEF_BANK_SEL_W;

    function automatic int bank_lsb(input int word_w);
        return WORD_LSB + word_w;
    endfunction

    function automatic int region_bit(input int word_w, input int bank_sel_w);
        return WORD_LSB + word_w + bank_sel_w;
    endfunction

    // 0-based Fibonacci: 1,1,2,3,5,... (wraps modulo 2**32).
    function automatic int unsigned fib(input int unsigned k);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        a = 1;
        b = 1;
        for (int unsigned i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/banked_mem_bank.sv
`default_nettype none
// ============================================================================
// Module   : banked_mem_bank
// Brief    : One RAM bank: synchronous write with enable, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module banked_mem_bank #(
    parameter int DATA_W = 8,
    parameter int WORD_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [WORD_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [WORD_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**WORD_W];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/banked_mem.sv
`default_nettype none
// ============================================================================
// Module   : banked_mem
// Brief    : Unified ROM/RAM banked memory with valid/ready request port,
//            fixed 2-cycle response pipeline and post-reset RAM clear.
//            BANKED_MEM_INIT_EN enables the RAM clear sweep after reset.
// Revision : 1.0 - initial release
// ============================================================================
module banked_mem
    import banked_mem_pkg::*;
#(
    parameter  int DATA_W     = DEF_DATA_W,
    parameter  int WORD_W     = DEF_WORD_W,
    parameter  int BANK_SEL_W = DEF_BANK_SEL_W,
    localparam int ADDR_W     = 1 + BANK_SEL_W + WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int C_BANKS      = 2**BANK_SEL_W;
    localparam int C_WORDS      = 2**WORD_W;
    localparam int C_BANK_LSB   = bank_lsb(WORD_W);
    localparam int C_REGION_BIT = region_bit(WORD_W, BANK_SEL_W);

    state_t              r_state;
    logic                r_run;
    logic                r_s1_valid;
    logic                r_s1_we;
    logic [ADDR_W-1:0]   r_s1_addr;
    logic [DATA_W-1:0]   r_s1_wdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_accept;
    logic [WORD_W-1:0]   w_s1_word;
    logic [BANK_SEL_W-1:0] w_s1_bank;
    logic                w_s1_region;
    logic                w_run_we;
    logic                w_init_we;
    logic [WORD_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic [DATA_W-1:0]   w_rd_data;
    logic [DATA_W-1:0]   w_bank_rdata [C_BANKS];
    logic [DATA_W-1:0]   w_rom [C_BANKS][C_WORDS];

`ifdef BANKED_MEM_INIT_EN
    logic [WORD_W-1:0]   r_init_cnt;
`endif

    // ------------------------------------------------------------------------
    // Sequencer: INIT sweeps every RAM word to zero, then RUN forever.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_run   <= 1'b0;
`ifdef BANKED_MEM_INIT_EN
            r_init_cnt <= '0;
`endif
        end else begin
            case (r_state)
                ST_INIT: begin
`ifdef BANKED_MEM_INIT_EN
                    r_init_cnt <= r_init_cnt + WORD_W'(1);
                    if (r_init_cnt == {WORD_W{1'b1}}) begin
                        r_state <= ST_RUN;
                        r_run   <= 1'b1;
                    end
`else
                    r_state <= ST_RUN;
                    r_run   <= 1'b1;
`endif
                end
                ST_RUN: begin
                    r_run <= 1'b1;
                end
                default: begin
                    r_state <= ST_INIT;
                    r_run   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_run;
    assign init_done = r_run;
    assign w_accept  = req_valid & r_run;

    // ------------------------------------------------------------------------
    // Stage 1: capture the accepted request.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_we    <= req_we;
            r_s1_addr  <= req_addr;
            r_s1_wdata <= req_wdata;
        end
    end

    assign w_s1_word   = r_s1_addr[WORD_LSB +: WORD_W];
    assign w_s1_bank   = r_s1_addr[C_BANK_LSB +: BANK_SEL_W];
    assign w_s1_region = r_s1_addr[C_REGION_BIT];

    // Gated by rst so a write caught in flight at reset is never committed.
    assign w_run_we = r_s1_valid & r_s1_we & w_s1_region & ~rst;

`ifdef BANKED_MEM_INIT_EN
    assign w_init_we = (r_state == ST_INIT) & ~rst;
    assign w_wr_addr = w_init_we ? r_init_cnt : w_s1_word;
    assign w_wr_data = w_init_we ? '0 : r_s1_wdata;
`else
    assign w_init_we = 1'b0;
    assign w_wr_addr = w_s1_word;
    assign w_wr_data = r_s1_wdata;
`endif

    // ------------------------------------------------------------------------
    // RAM banks and elaboration-time ROM table.
    // ------------------------------------------------------------------------
    generate
        for (genvar b = 0; b < C_BANKS; b++) begin : g_bank
            logic w_we;
            assign w_we = w_init_we | (w_run_we & (w_s1_bank == BANK_SEL_W'(b)));

            banked_mem_bank #(
                .DATA_W (DATA_W),
                .WORD_W (WORD_W)
            ) u_bank (
                .clk   (clk),
                .we    (w_we),
                .waddr (w_wr_addr),
                .wdata (w_wr_data),
                .raddr (w_s1_word),
                .rdata (w_bank_rdata[b])
            );
        end

        for (genvar rb = 0; rb < C_BANKS; rb++) begin : g_rom_bank
            for (genvar rw = 0; rw < C_WORDS; rw++) begin : g_rom_word
                localparam int unsigned C_VAL = fib(rw) + rb;
                assign w_rom[rb][rw] = C_VAL[DATA_W-1:0];
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Stage 2: RAM read sees all writes committed at earlier edges.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_data = '0;
        if (r_s1_valid && !r_s1_we) begin
            if (w_s1_region) begin
                w_rd_data = w_bank_rdata[w_s1_bank];
            end else begin
                w_rd_data = w_rom[w_s1_bank][w_s1_word];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= r_s1_valid;
            r_rsp_rdata <= w_rd_data;
            r_rsp_err   <= r_s1_valid & r_s1_we & ~w_s1_region;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_banked_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_banked_mem
// Brief    : Self-checking bench for banked_mem: directed vector table,
//            hand-written reset/hazard sequences and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_banked_mem;

`ifdef BANKED_MEM_INIT_EN
    localparam int N_INIT  = 8;
    localparam bit INIT_EN = 1'b1;
`else
    localparam int N_INIT  = 1;
    localparam bit INIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_we = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       init_done;

    banked_mem u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int since  = 0;
    bit seen_rst = 1'b0;

    int         fibs [8] = '{1, 1, 2, 3, 5, 8, 13, 21};
    logic [7:0] ram_m [64];
    bit         ram_k [64];

    typedef struct {
        int         due;
        bit         we;
        logic [6:0] addr;
        logic [7:0] wdata;
    } pend_t;
    pend_t pq [$];

    typedef struct {
        bit         we;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        bit         exp_err;
    } vec_t;
    vec_t vt [12];

    function automatic logic [7:0] rom_val(input int b, input int k);
        return 8'(fibs[k] + b);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, then compare against the model.
    task automatic step(input bit r, input bit v, input bit we,
                        input logic [6:0] a, input logic [7:0] d);
        bit         acc;
        pend_t      e;
        logic [5:0] idx;
        rst = r; req_valid = v; req_we = we; req_addr = a; req_wdata = d;
        acc = v && (req_ready === 1'b1) && !r;
        @(posedge clk);
        edge_n++;
        #1;
        if (r) begin
            seen_rst = 1'b1;
            since = 0;
            pq.delete();
        end else if (since < 100000) begin
            since++;
        end
        if (INIT_EN && !r && since == N_INIT) begin
            for (int i = 0; i < 64; i++) begin
                ram_m[i] = 8'h00;
                ram_k[i] = 1'b1;
            end
        end
        if (seen_rst) begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, since >= N_INIT});
            chk("init_done", {31'b0, init_done}, {31'b0, since >= N_INIT});
            if (pq.size() > 0 && pq[0].due == edge_n) begin
                e = pq.pop_front();
                idx = e.addr[5:0];
                chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
                if (e.we) begin
                    chk("wr_rdata", {24'b0, rsp_rdata}, 32'd0);
                    chk("wr_err", {31'b0, rsp_err}, {31'b0, ~e.addr[6]});
                    if (e.addr[6]) begin
                        ram_m[idx] = e.wdata;
                        ram_k[idx] = 1'b1;
                    end
                end else begin
                    chk("rd_err", {31'b0, rsp_err}, 32'd0);
                    if (!e.addr[6])
                        chk("rom_rdata", {24'b0, rsp_rdata}, {24'b0, rom_val(idx[5:3], idx[2:0])});
                    else if (ram_k[idx])
                        chk("ram_rdata", {24'b0, rsp_rdata}, {24'b0, ram_m[idx]});
                end
            end else begin
                chk("rsp_idle", {31'b0, rsp_valid}, 32'd0);
                if (r) begin
                    chk("rst_rdata", {24'b0, rsp_rdata}, 32'd0);
                    chk("rst_err", {31'b0, rsp_err}, 32'd0);
                end
            end
        end
        if (acc) pq.push_back('{edge_n + 1, we, a, d});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    endtask

    task automatic reset_and_wait(input string name);
        int low;
        step(1'b1, 1'b0, 1'b0, 7'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 7'h00, 8'h00);
        low = 0;
        while (req_ready !== 1'b1 && low < 40) begin
            idle();
            low++;
        end
        chk(name, low, N_INIT);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b0, 7'h0D, 8'h00, 8'h09, 1'b0};
        vt[1]  = '{1'b0, 7'h3F, 8'h00, 8'h1C, 1'b0};
        vt[2]  = '{1'b0, 7'h00, 8'h00, 8'h01, 1'b0};
        vt[3]  = '{1'b0, 7'h07, 8'h00, 8'h15, 1'b0};
        vt[4]  = '{1'b0, 7'h38, 8'h00, 8'h08, 1'b0};
        vt[5]  = '{1'b1, 7'h03, 8'hFF, 8'h00, 1'b1};
        vt[6]  = '{1'b0, 7'h03, 8'h00, 8'h03, 1'b0};
        vt[7]  = '{1'b1, 7'h52, 8'hA5, 8'h00, 1'b0};
        vt[8]  = '{1'b0, 7'h52, 8'h00, 8'hA5, 1'b0};
        vt[9]  = '{1'b1, 7'h7F, 8'h3C, 8'h00, 1'b0};
        vt[10] = '{1'b0, 7'h7F, 8'h00, 8'h3C, 1'b0};
        vt[11] = '{1'b0, 7'h21, 8'h00, 8'h05, 1'b0};

        reset_and_wait("init_len");

        if (INIT_EN) begin
            step(1'b0, 1'b1, 1'b0, 7'h40, 8'h00);
            idle();
            chk("init_ram_zero", {24'b0, rsp_rdata}, 32'h00);
        end

        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, vt[i].we, vt[i].addr, vt[i].wdata);
            idle();
            chk($sformatf("vec%0d_valid", i), {31'b0, rsp_valid}, 32'd1);
            chk($sformatf("vec%0d_rdata", i), {24'b0, rsp_rdata}, {24'b0, vt[i].exp_rdata});
            chk($sformatf("vec%0d_err", i), {31'b0, rsp_err}, {31'b0, vt[i].exp_err});
        end

        // Read-after-write on consecutive cycles.
        step(1'b0, 1'b1, 1'b1, 7'h52, 8'h5A);
        step(1'b0, 1'b1, 1'b0, 7'h52, 8'h00);
        idle();
        chk("raw_rdata", {24'b0, rsp_rdata}, 32'h5A);

        // Back-to-back writes to one word: the last one wins.
        step(1'b0, 1'b1, 1'b1, 7'h60, 8'h11);
        step(1'b0, 1'b1, 1'b1, 7'h60, 8'h22);
        step(1'b0, 1'b1, 1'b0, 7'h60, 8'h00);
        idle();
        chk("waw_rdata", {24'b0, rsp_rdata}, 32'h22);
        idle();

        // Randomized traffic, biased toward a few RAM words to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            logic [6:0] a;
            if ($urandom_range(1, 0) == 1)
                a = {1'b1, 3'($urandom_range(1, 0)), 3'($urandom_range(1, 0))};
            else
                a = 7'($urandom);
            step(1'b0, $urandom_range(3, 0) != 0, 1'($urandom), a, 8'($urandom));
        end
        idle();
        idle();

        // Reset with a read in flight: no response may appear.
        step(1'b0, 1'b1, 1'b0, 7'h52, 8'h00);
        reset_and_wait("init_len_flush");
        if (INIT_EN) begin
            step(1'b0, 1'b1, 1'b0, 7'h52, 8'h00);
            idle();
            chk("post_rst_ram", {24'b0, rsp_rdata}, 32'h00);
        end

        // Reset in the middle of the sweep restarts it from scratch.
        step(1'b1, 1'b0, 1'b0, 7'h00, 8'h00);
        idle();
        idle();
        idle();
        reset_and_wait("init_len_restart");

        step(1'b0, 1'b1, 1'b1, 7'h7F, 8'h3C);
        step(1'b0, 1'b1, 1'b0, 7'h7F, 8'h00);
        idle();
        chk("final_rdata", {24'b0, rsp_rdata}, 32'h3C);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/banked_mem.md
Name: banked_mem

Overview:
- Parametrised successor to the fixed 8-bank ROM/8-bank SRAM memory.
- Unified address space: the MSB selects the region (0 = ROM, 1 = RAM), the next field selects the bank, the low field selects the word.
- Adds a valid/ready request port, a pipelined response with error flagging, and a post-reset RAM clear sequencer.
- Sits between a bus master and local storage in datapath exercises.

Parameters:
- DATA_W, 8, data width in bits.
- WORD_W, 3, word-address bits per bank; each bank holds 2**WORD_W words.
- BANK_SEL_W, 3, bank-select bits; each region holds 2**BANK_SEL_W banks.
- Derived, not overridable: ADDR_W = 1 + BANK_SEL_W + WORD_W, which is 7 at the defaults.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when both valid and ready are high.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  address as {region, bank, word}.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  request was a write to the ROM region.
- init_done  out  1  high once the block is in RUN.

Behaviour:
- Reset: rst sampled at clk.
  - While rst is high, on the next edge: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
  - Pipeline stages are invalidated; in-flight requests produce no response.
  - RAM contents are unchanged by rst itself.
- State machine: INIT -> RUN.
  - rst forces INIT from any state, including mid-sweep.
  - INIT: a WORD_W-bit counter starts at 0. Each cycle it writes 0 to that word in every RAM bank in parallel.
  - After writing word 2**WORD_W-1 (counter wrap), go to RUN. INIT therefore lasts exactly 2**WORD_W cycles.
  - RUN: req_ready=1 and init_done=1. There is no exit from RUN except rst.
- ROM content: word k of bank b = (FIB[k] + b) truncated to DATA_W.
  - FIB = 1,1,2,3,5,8,13,21,34,55,...; index k is 0-based.
  - Computed at elaboration; the table is sized to 2**WORD_W entries.
- Pipeline: fixed 2-cycle latency, no response backpressure, one request per cycle sustained.
  - Edge E (accept): stage-1 registers capture we, addr, wdata.
  - Edge E+1 (stage 2):
    - RAM write to {bank, word} if we=1 and region=1.
    - rsp_valid=1, rsp_err = we & ~region.
    - rsp_rdata = ROM word if reading the ROM region; RAM word if reading the RAM region; 0 for any write.
    - The response is visible in the cycle after E+1.
- Hazards:
  - A RAM read reads the array at its own stage-2 edge, so a write accepted at E is seen by a read accepted at E+1 (read-after-write correct).
  - Two back-to-back writes to the same word: the last one wins.
- Writes to the ROM region have no effect on contents and always set rsp_err.
- Reads never flag an error. Every address is legal because the address space is power-of-two.
- Accepted requests are never dropped except by rst.

Optional Feature:
- Macro: BANKED_MEM_INIT_EN.
- Defined: the INIT sweep behaves as described above.
- Undefined:
  - The FSM enters RUN on the first edge after rst deasserts.
  - req_ready and init_done are high in the following cycle.
  - RAM contents are undefined until written; the bench must not check them.

Decomposition:
- Package banked_mem_pkg:
  - state enum {ST_INIT, ST_RUN};
  - function fib(k) for the ROM table;
  - localparam helpers for field offsets (WORD_LSB, BANK_LSB, REGION_BIT).
- Sub-module banked_mem_bank, one RAM bank:
  - synchronous write with enable, asynchronous read;
  - parameters DATA_W and WORD_W;
  - instantiated 2**BANK_SEL_W times in a generate loop.
- ROM is an elaboration-time constant mux in the top; it has no sub-module.

Test Plan (default parameters, BANKED_MEM_INIT_EN defined unless stated):
1. Assert rst 2 cycles, then release -> req_ready=0 for exactly 8 cycles, then 1. Read 7'h40 -> rsp_rdata=0x00, rsp_err=0.
2. Read 7'h0D (ROM, bank 1, word 5) -> rsp_valid exactly 2 cycles after acceptance, rsp_rdata = 8+1 = 0x09. Read 7'h3F -> 21+7 = 0x1C.
3. Write 0xA5 to 7'h52, then read 7'h52 on the very next cycle -> write rsp_rdata=0x00 with rsp_err=0; read rsp_rdata=0xA5.
4. Write 0xFF to 7'h03 (ROM) -> rsp_err=1. A following read of 7'h03 -> 0x03 with rsp_err=0.
5. Accept a read, then assert rst on the next cycle -> no rsp_valid appears. INIT restarts and RAM word 7'h52 reads 0 after init.
6. Macro undefined: release rst -> req_ready=1 in the second cycle after release. Write then read 7'h7F with 0x3C -> 0x3C.
